// File: rtl/s2p_receiver.sv
// s2p_receiver: serial-to-parallel receiver for the gated-clock serial link.
// Oversamples s_clk / s_clrn / sin in the clk domain, shifts in DATA_BITS bits
// per frame and presents the completed word on P_Data with a one-cycle valid.
// Mid-frame silence of TIMEOUT clk cycles drops the frame with a one-cycle err.
//
// Parameters:
//   DATA_BITS  frame length in bits (2..64)
//   DIR        1: LSB first, 0: MSB first
//   TIMEOUT    idle clk cycles mid-frame before the frame is dropped (>= 4)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   s_clk      serial clock, data sampled on its rise
//   s_clrn     active-low frame clear
//   sin        serial data
//   P_Data     last completed word (registered)
//   valid      one-cycle strobe, P_Data is new
//   busy       frame in progress
//   err        one-cycle strobe, frame dropped by timeout
// Build option:
//   S2P_RX_SYNC_EN  defined: two-flop synchronizers on all serial inputs
//                   (+2 cycles latency); undefined: inputs used directly.
module s2p_receiver #(
  parameter int DATA_BITS = 64,
  parameter int DIR       = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_clrn,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] P_Data,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic {IDLE, RECV} state_t;

  logic s_clk_s, s_clrn_s, sin_s;

`ifdef S2P_RX_SYNC_EN
  // bit 2: s_clk, bit 1: s_clrn, bit 0: sin. s_clk stages reset high so a
  // stuck-high s_clk cannot ripple through as a fake rise after reset.
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b110;
      sync2_q <= 3'b110;
    end else begin
      sync1_q <= {s_clk, s_clrn, sin};
      sync2_q <= sync1_q;
    end
  end

  assign s_clk_s  = sync2_q[2];
  assign s_clrn_s = sync2_q[1];
  assign sin_s    = sync2_q[0];
`else
  assign s_clk_s  = s_clk;
  assign s_clrn_s = s_clrn;
  assign sin_s    = sin;
`endif

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DATA_BITS-1:0]  p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  s_clk_dly_q;
  logic                  rise;

  assign rise = s_clk_s & ~s_clk_dly_q;

  always_comb begin
    if (DIR != 0) sr_shift = {sin_s, sr_q[DATA_BITS-1:1]};
    else          sr_shift = {sr_q[DATA_BITS-2:0], sin_s};
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    p_data_d = p_data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (!s_clrn_s) begin
      // clear wins over a coincident rise; the rise is not counted
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          tmo_d = '0;
          if (rise) begin
            sr_d    = sr_shift;
            cnt_d   = CNT_ONE;
            state_d = RECV;
          end
        end
        RECV: begin
          if (rise) begin
            sr_d  = sr_shift;
            tmo_d = '0;
            if (cnt_q == CNT_LAST) begin
              p_data_d = sr_shift;
              valid_d  = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      p_data_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      s_clk_dly_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      p_data_q    <= p_data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      s_clk_dly_q <= s_clk_s;
    end
  end

  assign P_Data = p_data_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign busy   = (state_q == RECV);

endmodule

// File: tb/tb_s2p_receiver.sv
// Directed bench for s2p_receiver: one 64-bit LSB-first instance and one
// 8-bit MSB-first instance with a short timeout, sharing the serial stimulus.
module tb_s2p_receiver;

`ifdef S2P_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst, s_clk, s_clrn, sin;
  logic [63:0] p64;
  logic [7:0]  p8;
  logic valid64, busy64, err64, valid8, busy8, err8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;

  logic [63:0] v64_q[$];
  int          v64_c[$];
  logic [7:0]  v8_q[$];
  int          v8_c[$];
  int          e8_c[$];

  s2p_receiver #(.DATA_BITS(64), .DIR(1), .TIMEOUT(1024)) u64 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sin(sin),
    .P_Data(p64), .valid(valid64), .busy(busy64), .err(err64)
  );

  s2p_receiver #(.DATA_BITS(8), .DIR(0), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sin(sin),
    .P_Data(p8), .valid(valid8), .busy(busy8), .err(err8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid64) begin v64_q.push_back(p64); v64_c.push_back(cyc); end
    if (valid8)  begin v8_q.push_back(p8);   v8_c.push_back(cyc);  end
    if (err8)    e8_c.push_back(cyc);
  end

  task automatic clear_q();
    v64_q.delete(); v64_c.delete(); v8_q.delete(); v8_c.delete(); e8_c.delete();
  endtask

  // Called at a negedge; low phase then high phase, ph cycles each.
  task automatic send_bit(input logic b, input int ph);
    sin = b;
    s_clk = 1'b0;
    repeat (ph) @(negedge clk);
    s_clk = 1'b1;
    last_rise = cyc + 1;
    repeat (ph) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w, input int n, input int dir, input int ph);
    for (int i = 0; i < n; i++) send_bit(dir != 0 ? w[i] : w[n-1-i], ph);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_clk = 1'b1; s_clrn = 1'b1; sin = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (p64 !== 64'h0) begin bad++; $display("FAIL reset_p64 got=%h want=0", p64); end
    total++; if (p8 !== 8'h0) begin bad++; $display("FAIL reset_p8 got=%h want=0", p8); end
    total++; if ({valid64, busy64, err64} !== 3'b000) begin bad++; $display("FAIL reset_flags64 got=%b want=000", {valid64, busy64, err64}); end
    total++; if ({valid8, busy8, err8} !== 3'b000) begin bad++; $display("FAIL reset_flags8 got=%b want=000", {valid8, busy8, err8}); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    // s_clk held high across reset release must not look like a rise
    total++; if ({busy64, busy8} !== 2'b00) begin bad++; $display("FAIL stuck_high_busy got=%b want=00", {busy64, busy8}); end
  endtask

  task automatic test_lsb64();
    clear_q();
    send_word(64'h0123_4567_89AB_CDEF, 64, 1, 4);
    repeat (4) @(negedge clk);
    total++; if (v64_q.size() !== 1) begin bad++; $display("FAIL lsb64_count got=%0d want=1", v64_q.size()); end
    else begin
      total++; if (v64_q[0] !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL lsb64_data got=%h want=0123456789abcdef", v64_q[0]); end
      total++; if (v64_c[0] !== last_rise + LAT) begin bad++; $display("FAIL lsb64_latency got=%0d want=%0d", v64_c[0], last_rise + LAT); end
    end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL lsb64_busy got=%b want=0", busy64); end
  endtask

  task automatic test_msb8();
    clear_q();
    send_word(64'hA5, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 1) begin bad++; $display("FAIL msb8_count got=%0d want=1", v8_q.size()); end
    else begin
      total++; if (v8_q[0] !== 8'hA5) begin bad++; $display("FAIL msb8_data got=%h want=a5", v8_q[0]); end
      total++; if (v8_c[0] !== last_rise + LAT) begin bad++; $display("FAIL msb8_latency got=%0d want=%0d", v8_c[0], last_rise + LAT); end
    end
    total++; if (e8_c.size() !== 0) begin bad++; $display("FAIL msb8_err got=%0d want=0", e8_c.size()); end
  endtask

  task automatic test_clear();
    clear_q();
    send_word(64'h1F, 5, 0, 2);
    s_clk = 1'b0; s_clrn = 1'b0;
    repeat (3) @(negedge clk);
    s_clrn = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", busy8); end
    send_word(64'h3C, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 1 || v8_q[0] !== 8'h3C) begin bad++; $display("FAIL clear_frame count=%0d got=%h want=3c", v8_q.size(), v8_q.size() > 0 ? v8_q[0] : 8'h0); end
    // clear coincident with a rise: that bit must not start/extend a frame
    clear_q();
    send_word(64'h5, 3, 0, 2);
    s_clk = 1'b0; sin = 1'b1;
    repeat (2) @(negedge clk);
    s_clk = 1'b1; s_clrn = 1'b0;
    repeat (2) @(negedge clk);
    s_clrn = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL clear_rise_busy got=%b want=0", busy8); end
    send_word(64'h96, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 1 || v8_q[0] !== 8'h96) begin bad++; $display("FAIL clear_rise_frame count=%0d got=%h want=96", v8_q.size(), v8_q.size() > 0 ? v8_q[0] : 8'h0); end
    total++; if (e8_c.size() !== 0) begin bad++; $display("FAIL clear_err got=%0d want=0", e8_c.size()); end
  endtask

  task automatic test_timeout();
    int r;
    clear_q();
    send_word(64'h7, 3, 0, 2);
    r = last_rise;
    s_clk = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (e8_c.size() !== 1) begin bad++; $display("FAIL tmo_count got=%0d want=1", e8_c.size()); end
    else begin
      total++; if (e8_c[0] !== r + LAT + 16) begin bad++; $display("FAIL tmo_cycle got=%0d want=%0d", e8_c[0], r + LAT + 16); end
    end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy8); end
    total++; if (p8 !== 8'h96) begin bad++; $display("FAIL tmo_pdata got=%h want=96", p8); end
    total++; if (v8_q.size() !== 0) begin bad++; $display("FAIL tmo_valid got=%0d want=0", v8_q.size()); end
    clear_q();
    send_word(64'h5A, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 1 || v8_q[0] !== 8'h5A) begin bad++; $display("FAIL tmo_next count=%0d got=%h want=5a", v8_q.size(), v8_q.size() > 0 ? v8_q[0] : 8'h0); end
  endtask

  task automatic test_rst_mid();
    clear_q();
    send_word(64'hC, 4, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({p8, valid8, busy8, err8} !== 11'h0) begin bad++; $display("FAIL rst_mid_outs got=%h/%b%b%b want=00/000", p8, valid8, busy8, err8); end
    repeat (4) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy8); end
    send_word(64'hC3, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 1 || v8_q[0] !== 8'hC3) begin bad++; $display("FAIL rst_mid_frame count=%0d got=%h want=c3", v8_q.size(), v8_q.size() > 0 ? v8_q[0] : 8'h0); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_word(64'hFF, 8, 0, 2);
    send_word(64'h00, 8, 0, 2);
    repeat (4) @(negedge clk);
    total++; if (v8_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", v8_q.size()); end
    else begin
      total++; if (v8_q[0] !== 8'hFF) begin bad++; $display("FAIL b2b_first got=%h want=ff", v8_q[0]); end
      total++; if (v8_q[1] !== 8'h00) begin bad++; $display("FAIL b2b_second got=%h want=00", v8_q[1]); end
    end
    total++; if (e8_c.size() !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", e8_c.size()); end
  endtask

  initial begin
    rst = 1'b1; s_clk = 1'b1; s_clrn = 1'b1; sin = 1'b0;
    @(negedge clk);
    test_reset();
    test_lsb64();
    test_msb8();
    test_clear();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel receiver: the receiving end of the gated-clock serial link driven by the team's parallel-to-serial shifter (`s_clk`, `s_clrn`, `sout`). It oversamples the serial clock and data in the system `clk` domain and shifts in `DATA_BITS` bits per frame. On frame completion it presents the word on `P_Data` with a one-cycle `valid` strobe. It is used wherever a board-side or loop-back serial stream must be turned back into a parallel word, for example in self-test of the display and LED shift chains.

## Interface
- `DATA_BITS`, default 64: frame length in bits (2..64).
- `DIR`, default 1: 1 means LSB first (first bit lands in `P_Data[0]`); 0 means MSB first (first bit lands in `P_Data[DATA_BITS-1]`).
- `TIMEOUT`, default 1024: number of `clk` cycles without an `s_clk` rise, mid-frame, before the frame is dropped (≥ 4).
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `s_clk`, input, 1: serial clock. Data is sampled on its rising edge.
- `s_clrn`, input, 1: active-low frame clear (abort).
- `sin`, input, 1: serial data.
- `P_Data`, output, `DATA_BITS`: last completed word. Registered.
- `valid`, output, 1: one-cycle strobe; `P_Data` is new.
- `busy`, output, 1: a frame is in progress (at least one bit received).
- `err`, output, 1: one-cycle strobe; frame dropped by timeout.

## Operation
- Internal: shift register `sr[DATA_BITS-1:0]`, bit counter `cnt` of width clog2(`DATA_BITS`+1), idle counter `tmo` of width clog2(`TIMEOUT`+1).
- Sampled signals: `s_clk_q`, `s_clrn_q`, `sin_q` (see Configuration). `s_clk_d` is `s_clk_q` delayed one cycle. `rise` = `s_clk_q` & ~`s_clk_d`.
- State machine: IDLE, RECV.
  - IDLE: `cnt`=0, `tmo`=0, `busy`=0. On `rise`: shift in `sin_q`, `cnt`=1, go to RECV. If `DATA_BITS`=1 this would complete; the minimum is 2.
  - RECV: on `rise`, shift in `sin_q`, `cnt`+=1, `tmo`=0. Otherwise `tmo`+=1.
  - RECV, `rise` with `cnt`==`DATA_BITS`-1: `P_Data` gets the assembled word including this bit, `valid`=1, go to IDLE.
  - RECV, `tmo`==`TIMEOUT`-1 with no `rise`: `err`=1, discard `sr`, go to IDLE. `P_Data` is unchanged.
- Shift rule:
  - DIR=1: `sr` <= {`sin_q`, `sr[DATA_BITS-1:1]`}.
  - DIR=0: `sr` <= {`sr[DATA_BITS-2:0]`, `sin_q`}.
- `s_clrn_q`=0: go to IDLE, `cnt`=0, `tmo`=0. No `valid`, no `err`. This has priority over a `rise` in the same cycle, and `rise` is ignored while `s_clrn_q`=0.
- `rst`=1: priority over everything. `P_Data`=0, `valid`=0, `busy`=0, `err`=0, `sr`=0, `cnt`=0, `tmo`=0, state IDLE, `s_clk_d`=1. Forcing `s_clk_d`=1 ensures a stuck-high `s_clk` after reset does not fake a rise.
- A `rise` in the same cycle that `valid` fires belongs to that frame. The next frame's first `rise` may occur in the very next sampled cycle, so back-to-back frames need no gap.
- `busy` = (state==RECV). It is combinational from state.

## Timing
- Reset values of all outputs: `P_Data`=0, `valid`=0, `busy`=0, `err`=0.
- Input constraints on `s_clk`:
  - With sync: high and low phases each ≥ 2 `clk` periods.
  - Without sync: high and low phases each ≥ 1 `clk` period.
  - `sin` stable for ≥ 1 `clk` before and after each `s_clk` rise.
- Latency, from the first `clk` edge at which the last `s_clk` rise is sampled high to `valid`=1:
  - With sync: 2 cycles.
  - Without sync: 0 cycles (`valid` is high after that same edge).
- `err` asserts exactly `TIMEOUT` cycles after the last detected `rise`.
- `valid` and `err` never assert in the same cycle, and neither lasts more than 1 cycle.

## Configuration
- Macro `S2P_RX_SYNC_EN`.
- Defined: two-flop synchronizers on `s_clk`, `s_clrn` and `sin`, for a fully asynchronous external link. Adds 2 cycles of latency on all inputs.
- Undefined: `s_clk_q`=`s_clk`, `s_clrn_q`=`s_clrn`, `sin_q`=`sin` (no synchronizer stages). Only legal when the source is synchronous to `clk`.

## Test plan
- DATA_BITS=64, DIR=1, sync on: send 64'h0123_4567_89AB_CDEF LSB first with 4-cycle `s_clk` phases. Expect exactly one `valid` with `P_Data`=64'h0123_4567_89AB_CDEF, 2 cycles after the final rise, and `busy` low the next cycle.
- DATA_BITS=8, DIR=0: send bits 1,0,1,0,0,1,0,1. Expect `P_Data`=8'hA5 and `err`=0 throughout.
- DATA_BITS=8: 5 bits, then `s_clrn` low for 3 cycles, then frame 8'h3C. Expect a single `valid` with `P_Data`=8'h3C and no `err`. Also assert `s_clrn` low coincident with a rise: that bit is not counted.
- DATA_BITS=8, TIMEOUT=16: 3 bits, then `s_clk` idle low for 20 cycles. Expect `err` pulse 16 cycles after the last rise, `busy`=0 afterwards, `P_Data` unchanged. A following full frame 8'h5A is received correctly.
- `rst` pulsed after 4 bits of a frame: all outputs 0 the next cycle; a following frame 8'hC3 yields `P_Data`=8'hC3.
- Two back-to-back frames 8'hFF then 8'h00 with no gap: two `valid` strobes, in order, with the correct values.
